// File: rtl/rem5_seq_tx.sv
// Serial frame transmitter feeding the rem5 detector: MSb-first bits, then an idle gap.
// Optional REM5_TX_EXPECT_EN adds the expected-remainder outputs o_exp_valid/o_exp_div.
module rem5_seq_tx #(
    parameter int WIDTH = 16,
    parameter int GAP = 1,
    localparam int LW = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic [LW-1:0]    i_load_len,
    output logic             o_valid,
    output logic             o_sequence,
    output logic             o_busy,
    output logic             o_done
`ifdef REM5_TX_EXPECT_EN
    ,
    output logic             o_exp_valid,
    output logic             o_exp_div
`endif
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [LW-1:0]    r_cnt;
    logic [GW-1:0]    r_gcnt;
    logic [LW-1:0]    w_len;
    logic [WIDTH-1:0] w_aligned;
    logic             w_accept;
    logic             w_last;
    logic             w_gap_end;

    // Zero or oversize lengths send the whole word
    assign w_len = ((i_load_len == '0) || (i_load_len > LW'(WIDTH))) ?
                   LW'(WIDTH) : i_load_len;
    assign w_aligned = i_load_data << (LW'(WIDTH) - w_len);

    assign w_accept = (r_state == S_IDLE) && i_load_valid;
    assign w_last = (r_state == S_SHIFT) && (r_cnt == '0);
    assign w_gap_end = (r_state == S_GAP) && (r_gcnt == '0);
    assign o_load_ready = (r_state == S_IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last) w_state_nxt = S_GAP;
            S_GAP:   if (w_gap_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_gcnt     <= '0;
            o_valid    <= 1'b0;
            o_sequence <= 1'b0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_busy <= (w_state_nxt != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        o_valid    <= 1'b1;
                        o_sequence <= w_aligned[WIDTH-1];
                        r_shift    <= w_aligned << 1;
                        r_cnt      <= w_len - 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_last) begin
                        o_valid    <= 1'b0;
                        o_sequence <= 1'b0;
                        o_done     <= 1'b1;
                        r_gcnt     <= GW'(GAP - 1);
                    end else begin
                        o_sequence <= r_shift[WIDTH-1];
                        r_shift    <= r_shift << 1;
                        r_cnt      <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (!w_gap_end) r_gcnt <= r_gcnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef REM5_TX_EXPECT_EN
    logic [2:0] r_rem;
    logic       r_pend;

    function automatic logic [2:0] f_rem(input logic [2:0] rem, input logic b);
        logic [3:0] t;
        t = {rem, b};
        return (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
    endfunction

    // Remainder tracks the bit being loaded onto o_sequence, so it is final
    // one cycle before the last bit leaves; the flag lands two cycles later.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rem       <= '0;
            r_pend      <= 1'b0;
            o_exp_valid <= 1'b0;
            o_exp_div   <= 1'b0;
        end else begin
            r_pend      <= w_last;
            o_exp_valid <= r_pend;
            o_exp_div   <= r_pend && (r_rem == '0);
            if (w_accept) begin
                r_rem <= f_rem(3'd0, w_aligned[WIDTH-1]);
            end else if ((r_state == S_SHIFT) && !w_last) begin
                r_rem <= f_rem(r_rem, r_shift[WIDTH-1]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rem5_seq_tx.sv
// Self-checking bench for rem5_seq_tx: GAP=1 and GAP=4 instances checked
// cycle by cycle against a timeline model built from frame length and payload.
module tb_rem5_seq_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lv1, lv4;
    logic [15:0] ld1, ld4;
    logic [4:0]  ll1, ll4;
    logic        rdy1, val1, seq1, busy1, done1, ev1, ed1;
    logic        rdy4, val4, seq4, busy4, done4, ev4, ed4;
    logic [6:0]  obs1, obs4, want;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    rem5_seq_tx #(.WIDTH(16), .GAP(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_load_valid(lv1), .o_load_ready(rdy1),
        .i_load_data(ld1), .i_load_len(ll1),
        .o_valid(val1), .o_sequence(seq1),
        .o_busy(busy1), .o_done(done1)
`ifdef REM5_TX_EXPECT_EN
        , .o_exp_valid(ev1), .o_exp_div(ed1)
`endif
    );

    rem5_seq_tx #(.WIDTH(16), .GAP(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_load_valid(lv4), .o_load_ready(rdy4),
        .i_load_data(ld4), .i_load_len(ll4),
        .o_valid(val4), .o_sequence(seq4),
        .o_busy(busy4), .o_done(done4)
`ifdef REM5_TX_EXPECT_EN
        , .o_exp_valid(ev4), .o_exp_div(ed4)
`endif
    );

`ifndef REM5_TX_EXPECT_EN
    assign ev1 = 1'b0;
    assign ed1 = 1'b0;
    assign ev4 = 1'b0;
    assign ed4 = 1'b0;
`endif

    assign obs1 = {rdy1, busy1, val1, seq1, done1, ev1, ed1};
    assign obs4 = {rdy4, busy4, val4, seq4, done4, ev4, ed4};

    localparam logic [6:0] QUIET = 7'b1000000;

    function automatic int eff_len(input logic [4:0] len);
        return ((len == 0) || (len > 16)) ? 16 : int'(len);
    endfunction

    // Expected outputs k cycles after the handshake cycle (k=0 is the handshake)
    function automatic logic [6:0] model(input logic [15:0] d, input logic [4:0] len,
                                         input int g, input int k);
        int L;
        logic v, s, dn, r, b, ev, ed;
`ifdef REM5_TX_EXPECT_EN
        int val;
`endif
        L  = eff_len(len);
        v  = (k >= 1) && (k <= L);
        s  = v ? d[L-k] : 1'b0;
        dn = (k == L + 1);
        r  = (k == 0) || (k >= L + g + 1);
        b  = (k >= 1) && (k <= L + g);
        ev = 1'b0;
        ed = 1'b0;
`ifdef REM5_TX_EXPECT_EN
        val = int'(d) & ((1 << L) - 1);
        ev  = (k == L + 2);
        ed  = ev && ((val % 5) == 0);
`endif
        return {r, b, v, s, dn, ev, ed};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (obs1 !== QUIET) begin
            bad++;
            $display("FAIL reset_in got=%b want=%b", obs1, QUIET);
        end
        total++;
        if (obs4 !== QUIET) begin
            bad++;
            $display("FAIL reset_in_g4 got=%b want=%b", obs4, QUIET);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (obs1 !== QUIET) begin
            bad++;
            $display("FAIL reset_out got=%b want=%b", obs1, QUIET);
        end
    endtask

    task automatic test_frames();
        logic [15:0] dv[$] = '{16'h000A, 16'h0007, 16'hF00F, 16'h0001, 16'hFFFF};
        logic [4:0]  lv[$] = '{5'd4, 5'd3, 5'd0, 5'd1, 5'd16};
        logic [15:0] d;
        logic [4:0]  len;
        for (int i = 0; i < 25; i++) begin
            d   = (i < dv.size()) ? dv[i] : 16'($urandom);
            len = (i < lv.size()) ? lv[i] : 5'($urandom);
            total++;
            if (rdy1 !== 1'b1) begin
                bad++;
                $display("FAIL frame_ready i=%0d got=%b want=1", i, rdy1);
            end
            lv1 = 1'b1;
            ld1 = d;
            ll1 = len;
            for (int k = 1; k <= eff_len(len) + 2; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    lv1 = 1'b0;
                    ld1 = 16'($urandom);
                    ll1 = 5'($urandom);
                end
                want = model(d, len, 1, k);
                total++;
                if (obs1 !== want) begin
                    bad++;
                    $display("FAIL frame i=%0d k=%0d got=%b want=%b", i, k, obs1, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        lv1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = (i % 2 == 0) ? 16'h0005 : 16'h0006;
            ld1 = d;
            ll1 = 5'd3;
            total++;
            if (rdy1 !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready i=%0d got=%b want=1", i, rdy1);
            end
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                if (k < 5) begin
                    ld1 = 16'($urandom);
                    ll1 = 5'($urandom);
                end
                want = model(d, 5'd3, 1, k);
                total++;
                if (obs1 !== want) begin
                    bad++;
                    $display("FAIL b2b i=%0d k=%0d got=%b want=%b", i, k, obs1, want);
                end
            end
        end
        lv1 = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [15:0] d;
        d = 16'($urandom) | 16'h0080;
        lv1 = 1'b1;
        ld1 = d;
        ll1 = 5'd8;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            lv1 = 1'b0;
            want = model(d, 5'd8, 1, k);
            total++;
            if (obs1 !== want) begin
                bad++;
                $display("FAIL pre_reset k=%0d got=%b want=%b", k, obs1, want);
            end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (obs1 !== QUIET) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", obs1, QUIET);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (obs1 !== QUIET) begin
                bad++;
                $display("FAIL post_reset c=%0d got=%b want=%b", c, obs1, QUIET);
            end
        end
        d = 16'($urandom);
        lv1 = 1'b1;
        ld1 = d;
        ll1 = 5'd8;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            lv1 = 1'b0;
            want = model(d, 5'd8, 1, k);
            total++;
            if (obs1 !== want) begin
                bad++;
                $display("FAIL after_reset k=%0d got=%b want=%b", k, obs1, want);
            end
        end
    endtask

    task automatic test_gap4();
        logic [15:0] d;
        logic [4:0]  len;
        int L;
        for (int i = 0; i < 6; i++) begin
            d   = (i == 0) ? 16'h0001 : 16'($urandom);
            len = (i == 0) ? 5'd1 : 5'($urandom_range(1, 10));
            L   = eff_len(len);
            total++;
            if (rdy4 !== 1'b1) begin
                bad++;
                $display("FAIL g4_ready i=%0d got=%b want=1", i, rdy4);
            end
            lv4 = 1'b1;
            ld4 = d;
            ll4 = len;
            for (int k = 1; k <= L + 5; k++) begin
                @(negedge clk);
                if ((k >= L + 1) && (k <= L + 4)) begin
                    lv4 = 1'($urandom_range(0, 1));
                    ld4 = 16'($urandom);
                    ll4 = 5'($urandom);
                end else begin
                    lv4 = 1'b0;
                end
                want = model(d, len, 4, k);
                total++;
                if (obs4 !== want) begin
                    bad++;
                    $display("FAIL g4 i=%0d k=%0d got=%b want=%b", i, k, obs4, want);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lv1 = 1'b0;
        lv4 = 1'b0;
        ld1 = '0;
        ld4 = '0;
        ll1 = '0;
        ll4 = '0;
        test_reset();
        test_frames();
        test_back_to_back();
        test_mid_reset();
        test_gap4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
